// File: rtl/memif_pkg.sv
// Shared types and widths for the memory-interface arbiter.
package memif_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CMD  = 2'd1,
      ST_DATA = 2'd2
   } state_e;

   localparam int MI_ADDR_W = 32;
   localparam int MI_LEN_W  = 7;
   localparam int MI_DATA_W = 16;

endpackage

// File: rtl/memif_arbiter_rr_pick.sv
// Round-robin picker: first requesting port at or after the pointer, wrapping mod N_PORTS.
module memif_arbiter_rr_pick #(
   parameter int N_PORTS = 2,
   parameter int SEL_W   = $clog2(N_PORTS)
) (
   input  logic [N_PORTS-1:0] req_i,
   input  logic [SEL_W-1:0]   ptr_i,
   output logic               found_o,
   output logic [SEL_W-1:0]   idx_o
);

   always_comb begin : pick
      int               cand;
      logic [SEL_W-1:0] c;
      found_o = 1'b0;
      idx_o   = '0;
      cand    = 0;
      c       = '0;
      // Scan farthest-first so the nearest requester overwrites and wins.
      for (int k = N_PORTS - 1; k >= 0; k--) begin
         cand = int'(ptr_i) + k;
         if (cand >= N_PORTS) cand = cand - N_PORTS;
         c = SEL_W'(cand);
         if (req_i[c]) begin
            found_o = 1'b1;
            idx_o   = c;
         end
      end
   end

endmodule

// File: rtl/memif_arbiter.sv
// Burst arbiter sharing one memory-controller interface among N DMA requesters.
//   state   | meaning
//   IDLE    | no grant; pick next requester round-robin
//   CMD     | command of port sel presented to the controller
//   DATA    | burst in flight; beats routed to port sel until last
module memif_arbiter
   import memif_pkg::*;
#(
   parameter int N_PORTS = 2
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [MI_ADDR_W*N_PORTS-1:0]   u_addr_i,
   input  logic [MI_LEN_W*N_PORTS-1:0]    u_len_i,
   input  logic [N_PORTS-1:0]             u_rw_i,
   input  logic [N_PORTS-1:0]             u_valid_i,
   output logic [N_PORTS-1:0]             u_ready_o,
   input  logic [MI_DATA_W*N_PORTS-1:0]   u_wdata_i,
   output logic [N_PORTS-1:0]             u_wack_o,
   output logic [N_PORTS-1:0]             u_wlast_o,
   output logic [MI_DATA_W-1:0]           u_rdata_o,
   output logic [N_PORTS-1:0]             u_rstb_o,
   output logic [N_PORTS-1:0]             u_rlast_o,
   output logic [MI_ADDR_W-1:0]           m_addr_o,
   output logic [MI_LEN_W-1:0]            m_len_o,
   output logic                           m_rw_o,
   output logic                           m_valid_o,
   input  logic                           m_ready_i,
   output logic [MI_DATA_W-1:0]           m_wdata_o,
   input  logic                           m_wack_i,
   input  logic                           m_wlast_i,
   input  logic [MI_DATA_W-1:0]           m_rdata_i,
   input  logic                           m_rstb_i,
   input  logic                           m_rlast_i,
   output logic                           busy_o
);

   localparam int SEL_W = $clog2(N_PORTS);

   state_e           state_q, state_d;
   logic [SEL_W-1:0] sel_q, sel_d;
   logic [SEL_W-1:0] ptr_q, ptr_d;
   logic             rw_q, rw_d;
   logic             pick_found;
   logic [SEL_W-1:0] pick_idx;

   memif_arbiter_rr_pick #(
      .N_PORTS (N_PORTS),
      .SEL_W   (SEL_W)
   ) u_pick (
      .req_i   (u_valid_i),
      .ptr_i   (ptr_q),
      .found_o (pick_found),
      .idx_o   (pick_idx)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         sel_q   <= '0;
         ptr_q   <= '0;
         rw_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
         ptr_q   <= ptr_d;
         rw_q    <= rw_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      sel_d     = sel_q;
      ptr_d     = ptr_q;
      rw_d      = rw_q;
      m_valid_o = 1'b0;
      u_ready_o = '0;
      u_wack_o  = '0;
      u_wlast_o = '0;
      u_rstb_o  = '0;
      u_rlast_o = '0;
      case (state_q)
         ST_IDLE: begin
            if (pick_found) begin
               sel_d   = pick_idx;
               state_d = ST_CMD;
            end
         end
         ST_CMD: begin
            m_valid_o = u_valid_i[sel_q];
            u_ready_o[sel_q] = u_valid_i[sel_q] & m_ready_i;
            if (u_valid_i[sel_q] && m_ready_i) begin
               rw_d    = u_rw_i[sel_q];
               state_d = ST_DATA;
            end else if (!u_valid_i[sel_q]) begin
               // Requester withdrew before accept: abandon without moving the pointer.
               state_d = ST_IDLE;
            end
         end
         ST_DATA: begin
            u_wack_o[sel_q]  = m_wack_i;
            u_wlast_o[sel_q] = m_wlast_i;
            u_rstb_o[sel_q]  = m_rstb_i;
            u_rlast_o[sel_q] = m_rlast_i;
            if ((!rw_q && m_wack_i && m_wlast_i) || (rw_q && m_rstb_i && m_rlast_i)) begin
               state_d = ST_IDLE;
               ptr_d   = (sel_q == SEL_W'(N_PORTS - 1)) ? '0 : sel_q + 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign m_addr_o  = u_addr_i[sel_q*MI_ADDR_W +: MI_ADDR_W];
   assign m_len_o   = u_len_i[sel_q*MI_LEN_W +: MI_LEN_W];
   assign m_rw_o    = u_rw_i[sel_q];
   assign m_wdata_o = u_wdata_i[sel_q*MI_DATA_W +: MI_DATA_W];
   assign u_rdata_o = m_rdata_i;
   assign busy_o    = (state_q != ST_IDLE);

endmodule

// File: tb/tb_memif_arbiter.sv
// Self-checking bench for memif_arbiter: table of single bursts plus hand-built corner sequences.
module tb_memif_arbiter;
   import memif_pkg::*;

   localparam int N = 2;

   logic            clk = 1'b0;
   logic            rst;
   logic [32*N-1:0] u_addr;
   logic [7*N-1:0]  u_len;
   logic [N-1:0]    u_rw, u_valid, u_ready;
   logic [16*N-1:0] u_wdata;
   logic [N-1:0]    u_wack, u_wlast, u_rstb, u_rlast;
   logic [15:0]     u_rdata;
   logic [31:0]     m_addr;
   logic [6:0]      m_len;
   logic            m_rw, m_valid, m_ready;
   logic [15:0]     m_wdata;
   logic            m_wack, m_wlast, m_rstb, m_rlast;
   logic [15:0]     m_rdata;
   logic            busy;

   always #5 clk = ~clk;

   memif_arbiter #(.N_PORTS(N)) dut (
      .clk       (clk),
      .rst       (rst),
      .u_addr_i  (u_addr),
      .u_len_i   (u_len),
      .u_rw_i    (u_rw),
      .u_valid_i (u_valid),
      .u_ready_o (u_ready),
      .u_wdata_i (u_wdata),
      .u_wack_o  (u_wack),
      .u_wlast_o (u_wlast),
      .u_rdata_o (u_rdata),
      .u_rstb_o  (u_rstb),
      .u_rlast_o (u_rlast),
      .m_addr_o  (m_addr),
      .m_len_o   (m_len),
      .m_rw_o    (m_rw),
      .m_valid_o (m_valid),
      .m_ready_i (m_ready),
      .m_wdata_o (m_wdata),
      .m_wack_i  (m_wack),
      .m_wlast_i (m_wlast),
      .m_rdata_i (m_rdata),
      .m_rstb_i  (m_rstb),
      .m_rlast_i (m_rlast),
      .busy_o    (busy)
   );

   typedef struct {
      int          port;
      logic [31:0] addr;
      logic [6:0]  len;
      logic        rw;
      logic [15:0] wdata;
   } exp_t;

   typedef struct {
      int          port;
      logic [31:0] addr;
      logic [6:0]  len;
      logic        rw;
      logic [15:0] wdata;
      int          rdy_dly;
   } vec_t;

   exp_t sb[$];
   int   n_vec = 0;
   int   n_err = 0;
   int   ptr_m = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic int pick(input logic [N-1:0] mask, input int ptr);
      for (int k = 0; k < N; k++)
         if (mask[(ptr + k) % N]) return (ptr + k) % N;
      return -1;
   endfunction

   task automatic request(input int p, input logic [31:0] a, input logic [6:0] l,
                          input logic rw, input logic [15:0] wd);
      exp_t e;
      u_addr[p*32 +: 32]  = a;
      u_len[p*7 +: 7]     = l;
      u_rw[p]             = rw;
      u_wdata[p*16 +: 16] = wd;
      u_valid[p]          = 1'b1;
      e.port = p; e.addr = a; e.len = l; e.rw = rw; e.wdata = wd;
      sb.push_back(e);
   endtask

   // Acts as the controller for one burst; checks command fields and beat routing.
   task automatic serve(input int rdy_dly, input bit drop, output int w);
      exp_t       e;
      int         own, other, lastpos, rderr;
      logic [N-1:0] pm;
      w = 0;
      while (m_valid !== 1'b1 && w < 20) begin
         tick(); #1; w++;
      end
      if (m_valid !== 1'b1) begin
         chk("grant_timeout", 0, 1);
         return;
      end
      if (sb.size() == 0) begin
         chk("scoreboard_empty", 0, 1);
         return;
      end
      e = sb.pop_front();
      pm = '0;
      pm[e.port] = 1'b1;
      chk("m_addr", m_addr, e.addr);
      chk("m_len", m_len, e.len);
      chk("m_rw", m_rw, e.rw);
      for (int i = 0; i < rdy_dly; i++) begin
         tick(); #1;
         chk("hold_valid", {m_valid, u_ready}, {1'b1, {N{1'b0}}});
      end
      tick(); m_ready = 1'b1; #1;
      chk("u_ready", u_ready, pm);
      tick(); m_ready = 1'b0;
      if (drop) u_valid[e.port] = 1'b0;
      #1;
      chk("data_state", {busy, m_valid}, 2'b10);
      chk("m_wdata", m_wdata, e.wdata);
      own = 0; other = 0; lastpos = -1; rderr = 0;
      for (int b = 0; b <= int'(e.len); b++) begin
         if (!e.rw) begin
            m_wack = 1'b1; m_wlast = (b == int'(e.len));
         end else begin
            m_rstb = 1'b1; m_rlast = (b == int'(e.len)); m_rdata = 16'(16'hA0 + b);
         end
         #1;
         if (!e.rw) begin
            own += int'(u_wack[e.port]);
            if (u_wlast[e.port]) lastpos = b;
            if ((u_wack & ~pm) != '0 || (u_wlast & ~pm) != '0) other++;
         end else begin
            own += int'(u_rstb[e.port]);
            if (u_rlast[e.port]) lastpos = b;
            if ((u_rstb & ~pm) != '0 || (u_rlast & ~pm) != '0) other++;
            if (u_rdata !== 16'(16'hA0 + b)) rderr++;
         end
         tick();
      end
      m_wack = 1'b0; m_wlast = 1'b0; m_rstb = 1'b0; m_rlast = 1'b0;
      #1;
      chk("beats_own", own, int'(e.len) + 1);
      chk("beats_other_port", other, 0);
      chk("last_beat_pos", lastpos, int'(e.len));
      if (e.rw) chk("rdata", rderr, 0);
      chk("busy_after_last", busy, 1'b0);
      ptr_m = (e.port + 1) % N;
   endtask

   initial begin
      vec_t vt[4];
      int   w, own, lp, pp;

      vt[0] = '{0, 32'h0000_0100, 7'd63, 1'b0, 16'h1234, 3};
      vt[1] = '{1, 32'h0000_2000, 7'd3,  1'b1, 16'h0000, 0};
      vt[2] = '{1, 32'hDEAD_BEE0, 7'd0,  1'b0, 16'h5A5A, 1};
      vt[3] = '{0, 32'h0000_0040, 7'd1,  1'b1, 16'h0000, 2};

      rst = 1'b1;
      u_addr = '0; u_len = '0; u_rw = '0; u_valid = '0; u_wdata = '0;
      m_ready = 1'b0; m_wack = 1'b0; m_wlast = 1'b0; m_rdata = '0;
      m_rstb = 1'b0; m_rlast = 1'b0;
      u_addr[31:0]  = 32'h1111_2222;
      u_addr[63:32] = 32'h3333_4444;
      #1;
      chk("reset_outputs", {busy, m_valid, u_ready, u_wack, u_wlast, u_rstb, u_rlast}, '0);
      chk("reset_maddr_sel0", m_addr, 32'h1111_2222);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;

      for (int i = 0; i < 4; i++) begin
         request(vt[i].port, vt[i].addr, vt[i].len, vt[i].rw, vt[i].wdata);
         #1;
         chk("no_comb_valid", m_valid, 1'b0);
         serve(vt[i].rdy_dly, 1'b1, w);
         chk("latency", w, 1);
         tick();
      end

      // Stray controller strobes while idle.
      m_wack = 1'b1; m_wlast = 1'b1; m_rstb = 1'b1; m_rlast = 1'b1;
      #1;
      chk("stray_routes", {u_wack, u_wlast, u_rstb, u_rlast}, '0);
      tick();
      m_wack = 1'b0; m_wlast = 1'b0; m_rstb = 1'b0; m_rlast = 1'b0;
      #1;
      chk("stray_state", {busy, m_valid}, 2'b00);

      // Contention: both ports request continuously, 4-beat writes.
      tick();
      lp = ptr_m;
      for (int k = 0; k < 4; k++) begin
         pp = pick(2'b11, lp);
         request(pp, (pp == 0) ? 32'h0000_0A00 : 32'h0000_0B00, 7'd3, 1'b0,
                 (pp == 0) ? 16'hC0C0 : 16'hC1C1);
         lp = (pp + 1) % N;
      end
      #1;
      for (int k = 0; k < 4; k++) begin
         serve(0, 1'b0, w);
         chk("one_idle_gap", w, 1);
      end
      u_valid = '0;
      tick();

      // Valid withdrawal in CMD; port1 pending behind it.
      u_addr[31:0] = 32'h0000_0C00; u_len[6:0] = 7'd3; u_rw[0] = 1'b0;
      u_valid[0] = 1'b1;
      tick(); #1;
      chk("wd_in_cmd", {busy, m_valid}, 2'b11);
      tick();
      u_valid[0] = 1'b0;
      request(1, 32'h0000_0D00, 7'd1, 1'b1, 16'h0000);
      #1;
      chk("wd_drop", {m_valid, u_ready}, '0);
      tick(); #1;
      chk("wd_back_idle", busy, 1'b0);
      serve(0, 1'b1, w);
      tick();

      // Async reset mid-DATA after 10 of 64 beats.
      u_addr[31:0] = 32'h0000_0500; u_len[6:0] = 7'd63; u_rw[0] = 1'b0; u_wdata[15:0] = 16'h7777;
      u_valid[0] = 1'b1;
      tick();
      m_ready = 1'b1;
      #1;
      chk("rm_accept", u_ready, 2'b01);
      tick();
      m_ready = 1'b0; u_valid[0] = 1'b0;
      own = 0;
      for (int b = 0; b < 10; b++) begin
         m_wack = 1'b1;
         #1;
         own += int'(u_wack[0]);
         tick();
      end
      chk("rm_beats_before_reset", own, 10);
      rst = 1'b1;
      #1;
      chk("rm_reset_outputs", {busy, m_valid, u_ready, u_wack, u_wlast, u_rstb, u_rlast}, '0);
      m_wack = 1'b0;
      tick();
      rst = 1'b0;
      ptr_m = 0;
      request(1, 32'h0000_0600, 7'd3, 1'b0, 16'hBEEF);
      #1;
      serve(0, 1'b1, w);
      chk("rm_post_reset_latency", w, 1);
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
